// File: rtl/lcd_seq_pkg.sv
// Shared constants, state encoding and helpers for the LCD repaint sequencer.
// LCD_SEQ_CURSOR_EN selects the cursor-on display command and the trailing cursor placement item.
package lcd_seq_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
`ifdef LCD_SEQ_CURSOR_EN
    localparam logic [7:0] CMD_DISP_ON  = 8'h0E;
`else
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
`endif
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;
    localparam logic [7:0] CHAR_BLANK   = 8'h20;

    localparam logic [5:0] INIT_LAST   = 6'd4;
    localparam logic [5:0] LINE2_ITEM  = 6'd21;
    localparam logic [5:0] ITEM_LAST   = 6'd37;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DELAY
    } seq_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_item_t;

    // Item index -> frame buffer cell for the two character runs (5..20, 22..37).
    function automatic logic [4:0] buf_index(input logic [5:0] idx);
        return (idx < LINE2_ITEM) ? 5'(idx - 6'd5) : 5'(idx - 6'd6);
    endfunction

    function automatic logic [7:0] cursor_cmd(input logic [4:0] addr);
        return addr[4] ? {4'hC, addr[3:0]} : {4'h8, addr[3:0]};
    endfunction

endpackage

// File: rtl/lcd_frame_buf.sv
// 32-cell character frame buffer: one synchronous write port, one combinational read port.
module lcd_frame_buf
    import lcd_seq_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       wr,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);

    logic [31:0][7:0] mem;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            mem <= {32{CHAR_BLANK}};
        else if (wr)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_sequencer.sv
// Drives the lcd write engine through init, then repaints the frame buffer on every write/refresh.
// Optional LCD_SEQ_CURSOR_EN: cursor shown, and each sweep ends by parking it on the last written cell.
module lcd_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 18'h3FFFE,
    parameter int          DLY_W        = 18
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iWR,
    input  logic [4:0] iADDR,
    input  logic [7:0] iWDATA,
    input  logic       iREFRESH,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_START,
    input  logic       iLCD_DONE,
    output logic       oBUSY,
    output logic       oINIT_DONE
);

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);

`ifdef LCD_SEQ_CURSOR_EN
    localparam logic [5:0] SWEEP_END = ITEM_LAST + 6'd1;
    logic [4:0] last_wr;
`else
    localparam logic [5:0] SWEEP_END = ITEM_LAST;
`endif

    seq_state_e       state, state_nxt;
    logic [5:0]       idx, idx_nxt;
    logic [DLY_W-1:0] dly, dly_nxt;
    logic             pend, launch, init_set;
    logic [7:0]       buf_rdata;
    lcd_item_t        item, out_q;

    lcd_frame_buf u_buf (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .wr     (iWR),
        .waddr  (iADDR),
        .wdata  (iWDATA),
        .raddr  (buf_index(idx)),
        .rdata  (buf_rdata)
    );

    always_comb begin
        item = '{rs: 1'b1, data: buf_rdata};
        case (idx)
            6'd0:  item = '{rs: 1'b0, data: CMD_FUNC_SET};
            6'd1:  item = '{rs: 1'b0, data: CMD_DISP_ON};
            6'd2:  item = '{rs: 1'b0, data: CMD_CLEAR};
            6'd3:  item = '{rs: 1'b0, data: CMD_ENTRY};
            6'd4:  item = '{rs: 1'b0, data: CMD_LINE1};
            6'd21: item = '{rs: 1'b0, data: CMD_LINE2};
`ifdef LCD_SEQ_CURSOR_EN
            6'd38: item = '{rs: 1'b0, data: cursor_cmd(last_wr)};
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dly_nxt   = dly;
        launch    = 1'b0;
        init_set  = 1'b0;
        case (state)
            ST_IDLE: if (pend) begin
                state_nxt = ST_LOAD;
                idx_nxt   = oINIT_DONE ? 6'd5 : 6'd0;
                launch    = 1'b1;
            end
            ST_LOAD:  state_nxt = ST_START;
            ST_START: if (!iLCD_DONE) state_nxt = ST_WAIT;
            ST_WAIT:  if (iLCD_DONE)  state_nxt = ST_DELAY;
            ST_DELAY: begin
                if (dly == DLY_LAST) begin
                    dly_nxt = '0;
                    if (idx == SWEEP_END) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_LOAD;
                        idx_nxt   = idx + 6'd1;
                        init_set  = (idx == INIT_LAST);
                    end
                end else begin
                    dly_nxt = dly + DLY_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= ST_IDLE;
            idx        <= '0;
            dly        <= '0;
            pend       <= 1'b1;
            oINIT_DONE <= 1'b0;
            out_q      <= '0;
            oLCD_START <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            dly   <= dly_nxt;
            // A request landing on the launch cycle must survive to force another sweep.
            pend  <= iWR | iREFRESH | (pend & ~launch);
            if (init_set)
                oINIT_DONE <= 1'b1;
            if (state == ST_LOAD)
                out_q <= item;
            oLCD_START <= (state_nxt == ST_START) || (state_nxt == ST_WAIT);
        end
    end

`ifdef LCD_SEQ_CURSOR_EN
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            last_wr <= '0;
        else if (iWR)
            last_wr <= iADDR;
    end
`endif

    assign oLCD_DATA = out_q.data;
    assign oLCD_RS   = out_q.rs;
    assign oBUSY     = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: sweep-level reference model plus directed scenarios with literal pins.
`timescale 1ns/1ps
module tb_lcd_sequencer;

`ifdef LCD_SEQ_CURSOR_EN
    localparam int         CUR   = 1;
    localparam logic [7:0] DISP  = 8'h0E;
`else
    localparam int         CUR   = 0;
    localparam logic [7:0] DISP  = 8'h0C;
`endif
    localparam int ITEMS = 38 + CUR;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b1;
    logic       iWR = 1'b0;
    logic [4:0] iADDR = '0;
    logic [7:0] iWDATA = '0;
    logic       iREFRESH = 1'b0;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS, oLCD_START, oBUSY, oINIT_DONE;
    logic       iLCD_DONE;

    always #5 iCLK = ~iCLK;

    lcd_sequencer #(.DELAY_CYCLES(4), .DLY_W(18)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iWR        (iWR),
        .iADDR      (iADDR),
        .iWDATA     (iWDATA),
        .iREFRESH   (iREFRESH),
        .oLCD_DATA  (oLCD_DATA),
        .oLCD_RS    (oLCD_RS),
        .oLCD_START (oLCD_START),
        .iLCD_DONE  (iLCD_DONE),
        .oBUSY      (oBUSY),
        .oINIT_DONE (oINIT_DONE)
    );

    // lcd write engine: drops done on a start edge, raises it again 20 cycles later.
    logic st_d;
    int   lcnt;
    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            iLCD_DONE <= 1'b1;
            st_d      <= 1'b0;
            lcnt      <= 0;
        end else begin
            st_d <= oLCD_START;
            if (oLCD_START && !st_d) begin
                iLCD_DONE <= 1'b0;
                lcnt      <= 20;
            end else if (lcnt > 0) begin
                lcnt <= lcnt - 1;
                if (lcnt == 1) iLCD_DONE <= 1'b1;
            end
        end
    end

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] mb [32];
    logic [4:0] m_last;
    bit         mpend, minit, prev_start;
    int         exp_q [$];
    int         cur_pos;
    logic [8:0] cur_exp;
    int         edges = 0;
    logic [8:0] obs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {RS,data} of list position pos, from the current model buffer.
    function automatic logic [8:0] exp_item(input int pos);
        int a;
        case (pos)
            0:  return 9'h038;
            1:  return {1'b0, DISP};
            2:  return 9'h001;
            3:  return 9'h006;
            4:  return 9'h080;
            21: return 9'h0C0;
            default: ;
        endcase
        if (pos <= 20) return {1'b1, mb[pos-5]};
        if (pos <= 37) return {1'b1, mb[pos-22+16]};
        a = int'(m_last);
        return {1'b0, 8'((a < 16) ? (128 + a) : (192 + a - 16))};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mb[i] = 8'h20;
        m_last     = '0;
        mpend      = 1'b1;
        minit      = 1'b0;
        prev_start = 1'b0;
        exp_q.delete();
        cur_pos    = -1;
        cur_exp    = '0;
    endtask

    task automatic model_step();
        if (!iRST_N) begin
            model_reset();
            return;
        end
        if (oLCD_START && !prev_start) begin
            edges++;
            obs.push_back({oLCD_RS, oLCD_DATA});
            if (exp_q.size() == 0 && mpend) begin
                for (int p = (minit ? 5 : 0); p < ITEMS; p++) exp_q.push_back(p);
                mpend = 1'b0;
            end
            chk("start_within_sweep", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                cur_pos = exp_q.pop_front();
                cur_exp = exp_item(cur_pos);
                if (cur_pos >= 5) minit = 1'b1;
                chk("init_done_at_item", oINIT_DONE, cur_pos >= 5);
            end
        end
        if (oLCD_START) chk("item", {oLCD_RS, oLCD_DATA}, cur_exp);
        if (exp_q.size() != 0 || oLCD_START) chk("busy_in_sweep", oBUSY, 1);
        prev_start = oLCD_START;
        if (iWR) begin
            mb[iADDR] = iWDATA;
            m_last    = iADDR;
            mpend     = 1'b1;
        end
        if (iREFRESH) mpend = 1'b1;
    endtask

    task automatic cyc();
        @(negedge iCLK);
        model_step();
    endtask

    task automatic wr(input int a, input int d);
        iADDR  = 5'(a);
        iWDATA = 8'(d);
        iWR    = 1'b1;
        cyc();
        iWR    = 1'b0;
    endtask

    task automatic refresh();
        iREFRESH = 1'b1;
        cyc();
        iREFRESH = 1'b0;
    endtask

    task automatic wait_pos(input int p, input int budget);
        int n = 0;
        while (cur_pos != p && n < budget) begin
            cyc();
            n++;
        end
        chk("wait_pos_reached", cur_pos, p);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (4) cyc();
        while ((oBUSY || exp_q.size() != 0 || mpend) && n < budget) begin
            cyc();
            n++;
        end
        chk("idle_reached", oBUSY, 0);
        chk("model_drained", exp_q.size() + int'(mpend), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, oLCD_DATA, 0);
        chk({tag, "_rs"}, oLCD_RS, 0);
        chk({tag, "_start"}, oLCD_START, 0);
        chk({tag, "_busy"}, oBUSY, 0);
        chk({tag, "_init_done"}, oINIT_DONE, 0);
    endtask

    int e0;

    initial begin
        model_reset();
        #1 iRST_N = 1'b0;
        cyc();
        cyc();
        chk_reset_outputs("reset");

        // Reset release: full init + paint
        iRST_N = 1'b1;
        e0 = edges;
        cyc();
        chk("first_start_cycle1", oLCD_START, 0);
        cyc();
        chk("first_start_cycle2", oLCD_START, 1);
        wait_idle(3000);
        chk("boot_len", edges - e0, ITEMS);
        chk("boot_item0", obs[e0+0], 9'h038);
        chk("boot_item1", obs[e0+1], {1'b0, DISP});
        chk("boot_item4", obs[e0+4], 9'h080);
        chk("boot_item5", obs[e0+5], 9'h120);
        chk("boot_item21", obs[e0+21], 9'h0C0);
        chk("boot_item37", obs[e0+37], 9'h120);
        chk("boot_init_done", oINIT_DONE, 1);

        // Write while idle: one 33-item sweep, no init
        e0 = edges;
        wr(16, 8'h35);
        wait_idle(3000);
        chk("wr_idle_len", edges - e0, 33 + CUR);
        chk("wr_idle_item22", obs[e0+17], 9'h135);

        // Write mid-sweep behind the cursor: old value now, new value in a second sweep
        e0 = edges;
        refresh();
        wait_pos(10, 1500);
        wr(3, 8'h2B);
        wait_idle(4000);
        chk("mid_len", edges - e0, 2 * (33 + CUR));
        chk("mid_sweep1_item8", obs[e0+3], 9'h120);
        chk("mid_sweep2_item8", obs[e0+33+CUR+3], 9'h12B);

        // Two refreshes during one sweep collapse into one extra sweep
        e0 = edges;
        refresh();
        wait_pos(8, 1500);
        refresh();
        wait_pos(25, 1500);
        refresh();
        wait_idle(4000);
        chk("collapse_len", edges - e0, 2 * (33 + CUR));

        // Reset mid-sweep: immediate return to reset values, then full rerun with blank cells
        refresh();
        wait_pos(12, 1500);
        iRST_N = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        cyc();
        cyc();
        iRST_N = 1'b1;
        e0 = edges;
        wait_idle(3000);
        chk("rerun_len", edges - e0, ITEMS);
        chk("rerun_item1", obs[e0+1], {1'b0, DISP});
        chk("rerun_item8", obs[e0+8], 9'h120);
        chk("rerun_item22", obs[e0+22], 9'h120);

`ifdef LCD_SEQ_CURSOR_EN
        chk("cursor_boot_tail", obs[e0+38], 9'h080);
        e0 = edges;
        wr(20, 8'h41);
        wait_idle(3000);
        chk("cursor_item26", obs[e0+21], 9'h141);
        chk("cursor_tail", obs[e0+33], 9'h0C4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
